// File: rtl/ppl_scanner_pkg.sv
// rtl/ppl_scanner_pkg.sv - shared widths, state encoding and end-address helper for the pixel scanner
package ppl_pkg;

  localparam int ADDR_W = 20;
  localparam int X_W    = 11;
  localparam int Y_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } ppl_state_e;

  localparam int H_DISP_DFLT = 1280;
  localparam int V_DISP_DFLT = 720;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DISP_DFLT * V_DISP_DFLT - 1);

  function automatic logic [ADDR_W-1:0] last_addr(input int h_disp, input int v_disp);
    return ADDR_W'(h_disp * v_disp - 1);
  endfunction

endpackage

// File: rtl/ppl_scanner_if.sv
// rtl/ppl_scanner_if.sv - scanner control inputs and pixel coordinate outputs
interface ppl_scanner_if;

  logic                      scanner_en;
  logic                      vs;
  logic [ppl_pkg::ADDR_W-1:0] pixel_addr_out;
  logic [ppl_pkg::X_W-1:0]    pixel_x;
  logic [ppl_pkg::Y_W-1:0]    pixel_y;
  logic                      pixel_valid;
  logic                      frame_done;

  modport slave (
    input  scanner_en, vs,
    output pixel_addr_out, pixel_x, pixel_y, pixel_valid, frame_done
  );

  modport master (
    output scanner_en, vs,
    input  pixel_addr_out, pixel_x, pixel_y, pixel_valid, frame_done
  );

endinterface

// File: rtl/ppl_scanner_tile_walker.sv
// rtl/ppl_scanner_tile_walker.sv - tile-order x/y/address stepper, raster inside each TILE x TILE tile
module ppl_tile_walker
  import ppl_pkg::*;
#(
  parameter int H_DISP = 1280,
  parameter int TILE   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_step,
  output logic [X_W-1:0]    o_x,
  output logic [Y_W-1:0]    o_y,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [X_W-1:0]    T_X_MAX = X_W'(TILE - 1);
  localparam logic [Y_W-1:0]    T_Y_MAX = Y_W'(TILE - 1);
  localparam logic [X_W-1:0]    TX_LAST = X_W'(H_DISP - TILE);
  localparam logic [X_W-1:0]    TILE_X  = X_W'(TILE);
  localparam logic [Y_W-1:0]    TILE_Y  = Y_W'(TILE);
  localparam logic [ADDR_W-1:0] TILE_A  = ADDR_W'(TILE);
  localparam logic [ADDR_W-1:0] LINE_A  = ADDR_W'(H_DISP);
  localparam logic [ADDR_W-1:0] BAND_A  = ADDR_W'(TILE * H_DISP);

  logic [X_W-1:0]    r_x, r_ix, r_tx0;
  logic [Y_W-1:0]    r_y, r_iy, r_ty0;
  logic [ADDR_W-1:0] r_addr, r_row, r_tbase, r_band;

  // r_row: address of the current tile row start, r_tbase: tile origin, r_band: tile-row origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clear) begin
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_ix    <= '0;
      r_iy    <= '0;
      r_tx0   <= '0;
      r_ty0   <= '0;
      r_row   <= '0;
      r_tbase <= '0;
      r_band  <= '0;
    end else if (i_step) begin
      if (r_ix != T_X_MAX) begin
        r_ix   <= r_ix + X_W'(1);
        r_x    <= r_x + X_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end else if (r_iy != T_Y_MAX) begin
        r_ix   <= '0;
        r_iy   <= r_iy + Y_W'(1);
        r_x    <= r_tx0;
        r_y    <= r_y + Y_W'(1);
        r_row  <= r_row + LINE_A;
        r_addr <= r_row + LINE_A;
      end else if (r_tx0 != TX_LAST) begin
        r_ix    <= '0;
        r_iy    <= '0;
        r_tx0   <= r_tx0 + TILE_X;
        r_x     <= r_tx0 + TILE_X;
        r_y     <= r_ty0;
        r_tbase <= r_tbase + TILE_A;
        r_row   <= r_tbase + TILE_A;
        r_addr  <= r_tbase + TILE_A;
      end else begin
        r_ix    <= '0;
        r_iy    <= '0;
        r_tx0   <= '0;
        r_ty0   <= r_ty0 + TILE_Y;
        r_x     <= '0;
        r_y     <= r_ty0 + TILE_Y;
        r_band  <= r_band + BAND_A;
        r_tbase <= r_band + BAND_A;
        r_row   <= r_band + BAND_A;
        r_addr  <= r_band + BAND_A;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_addr = r_addr;

endmodule

// File: rtl/ppl_scanner.sv
// rtl/ppl_scanner.sv - frame pixel scanner (raster order; tile order when PPL_SCANNER_TILE_EN is defined)
module ppl_scanner
  import ppl_pkg::*;
#(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int TILE   = 8
) (
  input  logic         clk,
  input  logic         rst,
  ppl_scanner_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST     = last_addr(H_DISP, V_DISP);
  localparam logic [ADDR_W-1:0] PRE_LAST = LAST - ADDR_W'(1);

  ppl_state_e        r_state, w_state_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_done, w_done_nxt;
  logic              w_clear, w_step;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic [ADDR_W-1:0] w_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // the last pixel is detected by address alone; it is unique in both scan orders
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_clear     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = SCAN;
        w_valid_nxt = 1'b1;
        w_clear     = 1'b1;
      end
      SCAN: begin
        if (bus.vs) begin
          w_valid_nxt = 1'b1;
          w_clear     = 1'b1;
        end else if (bus.scanner_en) begin
          if (w_addr == LAST) begin
            w_state_nxt = HOLD;
          end else begin
            w_step     = 1'b1;
            w_done_nxt = (w_addr == PRE_LAST);
          end
        end
      end
      HOLD: begin
        if (bus.vs) begin
          w_state_nxt = SCAN;
          w_valid_nxt = 1'b1;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef PPL_SCANNER_TILE_EN
  ppl_tile_walker #(
    .H_DISP (H_DISP),
    .TILE   (TILE)
  ) u_walker (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_step  (w_step),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_addr  (w_addr)
  );
`else
  localparam logic [X_W-1:0] X_MAX  = X_W'(H_DISP - 1);
  localparam logic [X_W-1:0] TILE_X = X_W'(TILE);

  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              w_unused_tile;

  // tile edge only matters in tile mode
  assign w_unused_tile = ^TILE_X;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_clear) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (w_step) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (r_x == X_MAX) begin
        r_x <= '0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign w_x    = r_x;
  assign w_y    = r_y;
  assign w_addr = r_addr;
`endif

  assign bus.pixel_x        = w_x;
  assign bus.pixel_y        = w_y;
  assign bus.pixel_addr_out = w_addr;
  assign bus.pixel_valid    = r_valid;
  assign bus.frame_done     = r_done;

endmodule

// File: tb/tb_ppl_scanner.sv
// tb/tb_ppl_scanner.sv - scoreboard bench for ppl_scanner (small 8x4 frame plus a wide-line invariant run)
`timescale 1ns/1ps
module tb_ppl_scanner;
  import ppl_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int T  = 2;
  localparam int N  = H * V;
  localparam int BH = 1280;
  localparam int BV = 16;

  typedef struct {
    int         idx;
    logic       done;
    ppl_state_e st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_b;
  always #5 clk = ~clk;

  ppl_scanner_if s_if();
  ppl_scanner_if b_if();

  ppl_scanner #(.H_DISP(H), .V_DISP(V), .TILE(T)) dut (
    .clk (clk),
    .rst (rst_s),
    .bus (s_if.slave)
  );

  ppl_scanner #(.H_DISP(BH), .V_DISP(BV), .TILE(8)) big (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if.slave)
  );

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         ord_x[N];
  int         ord_y[N];
  int         m_idx;
  ppl_state_e m_st;
  int         done_seen = 0;

  task automatic build_order();
    int k = 0;
`ifdef PPL_SCANNER_TILE_EN
    for (int ty = 0; ty < V / T; ty++)
      for (int tx = 0; tx < H / T; tx++)
        for (int iy = 0; iy < T; iy++)
          for (int ix = 0; ix < T; ix++) begin
            ord_x[k] = tx * T + ix;
            ord_y[k] = ty * T + iy;
            k++;
          end
`else
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        ord_x[k] = x;
        ord_y[k] = y;
        k++;
      end
`endif
  endtask

  // drive one cycle, push the model's expectation, then pop it against the DUT output
  task automatic drive_cycle(input logic en, input logic v, input logic rel);
    exp_t        e;
    logic [19:0] a_exp;
    @(negedge clk);
    s_if.scanner_en = en;
    s_if.vs         = v;
    e.done          = 1'b0;
    if (rel) begin
      rst_s = 1'b0;
      m_idx = 0;
      m_st  = SCAN;
    end else if (v) begin
      m_idx = 0;
      m_st  = SCAN;
    end else if (m_st == SCAN && en) begin
      if (m_idx == N - 1) m_st = HOLD;
      else begin
        m_idx++;
        e.done = (m_idx == N - 1);
      end
    end
    e.idx = m_idx;
    e.st  = m_st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e     = sb.pop_front();
    a_exp = 20'(ord_y[e.idx] * H + ord_x[e.idx]);
    checks++;
    if (s_if.pixel_x !== 11'(ord_x[e.idx])) begin
      errors++;
      $display("FAIL sb_x idx=%0d got=%0d exp=%0d", e.idx, s_if.pixel_x, ord_x[e.idx]);
    end
    checks++;
    if (s_if.pixel_y !== 10'(ord_y[e.idx])) begin
      errors++;
      $display("FAIL sb_y idx=%0d got=%0d exp=%0d", e.idx, s_if.pixel_y, ord_y[e.idx]);
    end
    checks++;
    if (s_if.pixel_addr_out !== a_exp) begin
      errors++;
      $display("FAIL sb_addr idx=%0d got=%0d exp=%0d", e.idx, s_if.pixel_addr_out, a_exp);
    end
    checks++;
    if (s_if.frame_done !== e.done) begin
      errors++;
      $display("FAIL sb_done idx=%0d got=%b exp=%b", e.idx, s_if.frame_done, e.done);
    end
    checks++;
    if (dut.r_state !== e.st) begin
      errors++;
      $display("FAIL sb_state idx=%0d got=%0d exp=%0d", e.idx, dut.r_state, e.st);
    end
    if (e.st == SCAN) begin
      checks++;
      if (s_if.pixel_valid !== 1'b1) begin
        errors++;
        $display("FAIL sb_valid idx=%0d got=%b exp=1", e.idx, s_if.pixel_valid);
      end
    end
    if (s_if.frame_done === 1'b1) done_seen++;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (s_if.pixel_addr_out !== 20'd0 || s_if.pixel_x !== 11'd0 || s_if.pixel_y !== 10'd0) begin
      errors++;
      $display("FAIL rst_coord got addr=%0d x=%0d y=%0d exp=0", s_if.pixel_addr_out, s_if.pixel_x, s_if.pixel_y);
    end
    checks++;
    if (s_if.pixel_valid !== 1'b0 || s_if.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got valid=%b done=%b exp=0", s_if.pixel_valid, s_if.frame_done);
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL rst_state got=%0d exp=%0d", dut.r_state, IDLE);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_raster();
    int d0 = done_seen;
    repeat (N - 1) drive_cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (s_if.pixel_addr_out !== 20'd31 || done_seen - d0 != 1) begin
      errors++;
      $display("FAIL raster_end got addr=%0d pulses=%0d exp addr=31 pulses=1", s_if.pixel_addr_out, done_seen - d0);
    end
    repeat (10) drive_cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (dut.r_state !== HOLD || s_if.pixel_addr_out !== 20'd31 || done_seen - d0 != 1) begin
      errors++;
      $display("FAIL raster_hold got state=%0d addr=%0d pulses=%0d exp state=%0d addr=31 pulses=1",
               dut.r_state, s_if.pixel_addr_out, done_seen - d0, HOLD);
    end
  endtask

  task automatic test_stall();
    logic [19:0] a7;
    drive_cycle(1'b0, 1'b1, 1'b0);
    repeat (5) drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    a7 = 20'(ord_y[7] * H + ord_x[7]);
    checks++;
    if (s_if.pixel_addr_out !== a7) begin
      errors++;
      $display("FAIL stall_end got=%0d exp=%0d", s_if.pixel_addr_out, a7);
    end
  endtask

  task automatic test_restart();
    repeat (10) drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (s_if.pixel_addr_out !== 20'd0 || s_if.pixel_x !== 11'd0 || s_if.pixel_y !== 10'd0 ||
        dut.r_state !== SCAN || s_if.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL restart got addr=%0d x=%0d y=%0d state=%0d done=%b exp 0/0/0/%0d/0",
               s_if.pixel_addr_out, s_if.pixel_x, s_if.pixel_y, dut.r_state, s_if.frame_done, SCAN);
    end
  endtask

`ifdef PPL_SCANNER_TILE_EN
  task automatic test_tile();
    int ex[6] = '{0, 1, 0, 1, 2, 3};
    int ey[6] = '{0, 0, 1, 1, 0, 0};
    int d0 = done_seen;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (s_if.pixel_x !== 11'(ex[i]) || s_if.pixel_y !== 10'(ey[i])) begin
        errors++;
        $display("FAIL tile_first%0d got=(%0d,%0d) exp=(%0d,%0d)", i, s_if.pixel_x, s_if.pixel_y, ex[i], ey[i]);
      end
    end
    repeat (N - 6) drive_cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (s_if.pixel_x !== 11'd7 || s_if.pixel_y !== 10'd3 || s_if.pixel_addr_out !== 20'd31 || done_seen - d0 != 1) begin
      errors++;
      $display("FAIL tile_end got=(%0d,%0d) addr=%0d pulses=%0d exp=(7,3) addr=31 pulses=1",
               s_if.pixel_x, s_if.pixel_y, s_if.pixel_addr_out, done_seen - d0);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int d0;
    drive_cycle(1'b0, 1'b1, 1'b0);
    repeat (12) drive_cycle(1'b1, 1'b0, 1'b0);
    d0 = done_seen;
    @(negedge clk);
    rst_s = 1'b1;
    s_if.scanner_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (s_if.pixel_addr_out !== 20'd0 || s_if.pixel_x !== 11'd0 || s_if.pixel_y !== 10'd0 ||
          s_if.pixel_valid !== 1'b0 || s_if.frame_done !== 1'b0 || dut.r_state !== IDLE) begin
        errors++;
        $display("FAIL rst_mid%0d got addr=%0d x=%0d y=%0d valid=%b done=%b state=%0d exp all 0 IDLE",
                 i, s_if.pixel_addr_out, s_if.pixel_x, s_if.pixel_y, s_if.pixel_valid, s_if.frame_done, dut.r_state);
      end
      @(posedge clk);
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (done_seen != d0) begin
      errors++;
      $display("FAIL rst_mid_done got pulses=%0d exp=0", done_seen - d0);
    end
  endtask

  task automatic test_invariant();
    int ens = 0;
    int cyc = 0;
    int dn  = 0;
    b_if.scanner_en = 1'b0;
    b_if.vs         = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    while (ens < BH * BV && cyc < 60000) begin
      @(negedge clk);
      b_if.scanner_en = ($urandom_range(0, 3) != 0);
      if (b_if.scanner_en) ens++;
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (b_if.pixel_addr_out !== 20'(int'(b_if.pixel_y) * BH + int'(b_if.pixel_x))) begin
        errors++;
        $display("FAIL inv_addr got=%0d x=%0d y=%0d", b_if.pixel_addr_out, b_if.pixel_x, b_if.pixel_y);
      end
      checks++;
      if (int'(b_if.pixel_x) >= BH || int'(b_if.pixel_y) >= BV) begin
        errors++;
        $display("FAIL inv_range got x=%0d y=%0d limits %0d/%0d", b_if.pixel_x, b_if.pixel_y, BH, BV);
      end
      if (b_if.frame_done === 1'b1) begin
        dn++;
        checks++;
        if (b_if.pixel_addr_out !== 20'(BH * BV - 1)) begin
          errors++;
          $display("FAIL inv_done_addr got=%0d exp=%0d", b_if.pixel_addr_out, BH * BV - 1);
        end
      end
    end
    checks++;
    if (cyc >= 60000) begin
      errors++;
      $display("FAIL inv_timeout got cycles=%0d exp <60000", cyc);
    end
    checks++;
    if (big.r_state !== HOLD || b_if.pixel_addr_out !== 20'(BH * BV - 1) || dn != 1) begin
      errors++;
      $display("FAIL inv_end got state=%0d addr=%0d pulses=%0d exp state=%0d addr=%0d pulses=1",
               big.r_state, b_if.pixel_addr_out, dn, HOLD, BH * BV - 1);
    end
  endtask

  initial begin
    rst_s = 1'b1;
    rst_b = 1'b1;
    s_if.scanner_en = 1'b0;
    s_if.vs         = 1'b0;
    b_if.scanner_en = 1'b0;
    b_if.vs         = 1'b0;
    m_idx = 0;
    m_st  = IDLE;
    build_order();
    repeat (3) @(posedge clk);
    test_reset();
    test_raster();
    test_stall();
    test_restart();
`ifdef PPL_SCANNER_TILE_EN
    test_tile();
`endif
    test_reset_mid();
    test_invariant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
